ram_loader: RTL and testbench

//  Bus-side initiator for the 16x8 SAP RAM. Takes a byte stream (UART rx or button-stepped dipswitches)
//  and runs the RAM's MAR-load and write strobes to fill every address from 0 upward.

---
 rtl/ram_loader_pkg.sv | 25 ++
 rtl/ram_loader.sv | 157 +++++++++++++++
 tb/tb_ram_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_loader_pkg.sv
// rtl/ram_loader_pkg.sv - SAP bus widths, RAM/MAR control polarities and loader state encoding
package ram_loader_pkg;

  localparam int SAP_ADDR_WIDTH = 4;
  localparam int SAP_DATA_WIDTH = 8;

  // Asserted levels of the SAP RAM/MAR controls; the ram block decodes the same constants.
  localparam logic MAR_CLEAR_ON  = 1'b1;
  localparam logic MAR_LOAD_ON   = 1'b0;
  localparam logic RAM_WRITE_ON  = 1'b0;
  localparam logic RAM_OUTPUT_ON = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR,
    ST_WAIT,
    ST_ADDR,
    ST_WRITE,
    ST_VADDR,
    ST_VREAD,
    ST_VCHK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - streams an image into the SAP RAM via MAR-load/write strobes, optional readback check
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = SAP_ADDR_WIDTH,
  parameter int DATA_WIDTH = SAP_DATA_WIDTH,
  parameter bit VERIFY     = 1'b1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] bus_in,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  bus_drive,
  output logic                  clear_addr_reg,
  output logic                  load_addr_reg,
  output logic                  write_enable,
  output logic                  output_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] checksum
);

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   addr, addr_d;
  logic [DATA_WIDTH-1:0]   byte_q, vsum;
  logic                    last_addr;

  logic                    in_ready_d, bus_drive_d, clear_addr_d, load_addr_d;
  logic                    write_enable_d, output_enable_d, busy_d, done_d;
  logic [DATA_WIDTH-1:0]   bus_out_d;

  assign last_addr = &addr;

  // Outputs are decoded from next_state and registered, so every strobe is a clean one-cycle pulse.
  always_ff @(posedge clk) begin
    if (clear) begin
      state          <= ST_IDLE;
      in_ready       <= 1'b0;
      bus_out        <= '0;
      bus_drive      <= 1'b0;
      clear_addr_reg <= ~MAR_CLEAR_ON;
      load_addr_reg  <= ~MAR_LOAD_ON;
      write_enable   <= ~RAM_WRITE_ON;
      output_enable  <= ~RAM_OUTPUT_ON;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= next_state;
      in_ready       <= in_ready_d;
      bus_out        <= bus_out_d;
      bus_drive      <= bus_drive_d;
      clear_addr_reg <= clear_addr_d;
      load_addr_reg  <= load_addr_d;
      write_enable   <= write_enable_d;
      output_enable  <= output_enable_d;
      busy           <= busy_d;
      done           <= done_d;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (start) next_state = ST_CLR;
      ST_CLR:   next_state = ST_WAIT;
      ST_WAIT:  if (in_valid) next_state = ST_ADDR;
      ST_ADDR:  next_state = ST_WRITE;
      ST_WRITE: begin
        if (!last_addr)  next_state = ST_WAIT;
        else if (VERIFY) next_state = ST_VADDR;
        else             next_state = ST_DONE;
      end
      ST_VADDR: next_state = ST_VREAD;
      ST_VREAD: next_state = last_addr ? ST_VCHK : ST_VADDR;
      ST_VCHK:  next_state = ST_DONE;
      ST_DONE:  if (start) next_state = ST_CLR;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr;
    case (state)
      ST_CLR:             addr_d = '0;
      ST_WRITE, ST_VREAD: addr_d = addr + 1'b1;
      default:            ;
    endcase
  end

  always_comb begin
    in_ready_d      = 1'b0;
    bus_drive_d     = 1'b0;
    bus_out_d       = '0;
    clear_addr_d    = ~MAR_CLEAR_ON;
    load_addr_d     = ~MAR_LOAD_ON;
    write_enable_d  = ~RAM_WRITE_ON;
    output_enable_d = ~RAM_OUTPUT_ON;
    busy_d          = 1'b1;
    done_d          = 1'b0;
    case (next_state)
      ST_IDLE:  busy_d = 1'b0;
      ST_CLR:   clear_addr_d = MAR_CLEAR_ON;
      ST_WAIT:  in_ready_d = 1'b1;
      ST_ADDR, ST_VADDR: begin
        bus_drive_d = 1'b1;
        bus_out_d   = DATA_WIDTH'(addr_d);
        load_addr_d = MAR_LOAD_ON;
      end
      ST_WRITE: begin
        bus_drive_d    = 1'b1;
        bus_out_d      = byte_q;
        write_enable_d = RAM_WRITE_ON;
      end
      // Bus is released here so the RAM can drive it without contention.
      ST_VREAD: output_enable_d = RAM_OUTPUT_ON;
      ST_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      addr     <= '0;
      byte_q   <= '0;
      checksum <= '0;
      vsum     <= '0;
      error    <= 1'b0;
    end else begin
      addr <= addr_d;
      case (state)
        ST_CLR: begin
          checksum <= '0;
          error    <= 1'b0;
        end
        ST_WAIT: begin
          if (in_valid) begin
            byte_q   <= in_data;
            checksum <= checksum + in_data;
          end
        end
        ST_WRITE: if (last_addr) vsum <= '0;
        ST_VREAD: vsum <= vsum + bus_in;
        ST_VCHK:  error <= (vsum != checksum);
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - table-driven random bench for ram_loader with RAM models and a handshake timeline model
module tb_ram_loader;

  localparam int N = 16;

  typedef struct {
    int         kind;
    int         rate;
    int         gap_after;
    int         gap_len;
    int         mid_start;
    int         abort_byte;
    int         corrupt;
    bit         has_ck;
    logic [7:0] exp_ck;
    int         exp_done_n;
    int         exp_done_v;
  } row_t;

  logic       clk = 1'b0;
  logic       clear, start, in_valid, fill_req;
  logic [7:0] in_data;

  logic       in_ready_v, bus_drive_v, clear_addr_reg_v, load_addr_reg_v;
  logic       write_enable_v, output_enable_v, busy_v, done_v, error_v;
  logic [7:0] bus_in_v, bus_out_v, checksum_v;
  logic       in_ready_n, bus_drive_n, clear_addr_reg_n, load_addr_reg_n;
  logic       write_enable_n, output_enable_n, busy_n, done_n, error_n;
  logic [7:0] bus_in_n, bus_out_n, checksum_n;

  logic [7:0] ram_v [N];
  logic [7:0] ram_n [N];
  logic [7:0] img   [N];
  logic [3:0] mar_v, mar_n;
  int         corrupt_idx = -1;
  int         contention = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  row_t       tbl [8];

  always #5 clk = ~clk;

  ram_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .VERIFY(1'b1)) dut_v (
    .clk(clk), .clear(clear), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_v), .bus_in(bus_in_v), .bus_out(bus_out_v), .bus_drive(bus_drive_v),
    .clear_addr_reg(clear_addr_reg_v), .load_addr_reg(load_addr_reg_v),
    .write_enable(write_enable_v), .output_enable(output_enable_v),
    .busy(busy_v), .done(done_v), .error(error_v), .checksum(checksum_v));

  ram_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .VERIFY(1'b0)) dut_n (
    .clk(clk), .clear(clear), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_n), .bus_in(bus_in_n), .bus_out(bus_out_n), .bus_drive(bus_drive_n),
    .clear_addr_reg(clear_addr_reg_n), .load_addr_reg(load_addr_reg_n),
    .write_enable(write_enable_n), .output_enable(output_enable_n),
    .busy(busy_n), .done(done_n), .error(error_n), .checksum(checksum_n));

  assign bus_in_v = bus_drive_v ? bus_out_v : (output_enable_v == 1'b0 ? ram_v[mar_v] : 8'h00);
  assign bus_in_n = bus_drive_n ? bus_out_n : (output_enable_n == 1'b0 ? ram_n[mar_n] : 8'h00);

  // SAP RAM + MAR models; the verify-side RAM can corrupt one address as it is written.
  always @(posedge clk) begin
    if (fill_req)
      for (int i = 0; i < N; i++) begin
        ram_v[i] <= ~img[i];
        ram_n[i] <= ~img[i];
      end
    if (clear_addr_reg_v) mar_v <= '0;
    else if (!load_addr_reg_v) mar_v <= bus_in_v[3:0];
    if (clear_addr_reg_n) mar_n <= '0;
    else if (!load_addr_reg_n) mar_n <= bus_in_n[3:0];
    if (!write_enable_v)
      ram_v[mar_v] <= (int'(mar_v) == corrupt_idx) ? ((bus_in_v == 8'hFF) ? 8'h00 : 8'hFF) : bus_in_v;
    if (!write_enable_n) ram_n[mar_n] <= bus_in_n;
  end

  always @(negedge clk)
    if ((bus_drive_v && !output_enable_v) || (bus_drive_n && !output_enable_n)) contention++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " reset outputs (verify)"},
          {in_ready_v, bus_out_v, bus_drive_v, clear_addr_reg_v, load_addr_reg_v, write_enable_v,
           output_enable_v, busy_v, done_v, error_v, checksum_v},
          {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    check({tag, " reset outputs (no verify)"},
          {in_ready_n, bus_out_n, bus_drive_n, clear_addr_reg_n, load_addr_reg_n, write_enable_n,
           output_enable_n, busy_n, done_n, error_n, checksum_n},
          {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
  endtask

  // Expected {mar_clear, mar_load_n, we_n, oe_n, in_ready, bus_drive, busy, done} at cycle t after start.
  function automatic logic [7:0] exp_vec(input bit vf, input int t, input int k, input int rdy,
                                         input int addr_t, input int write_t, input int last_write);
    bit clr, ld, wr, rd, ir, dn;
    int u;
    clr = (t == 0);
    ld  = (t == addr_t);
    wr  = (t == write_t);
    rd  = 1'b0;
    dn  = 1'b0;
    ir  = (k < N) && (t >= rdy);
    if (k == N && t > last_write) begin
      u = t - last_write - 1;
      if (!vf) dn = 1'b1;
      else if (u < 2 * N) begin
        if (u % 2 == 0) ld = 1'b1;
        else rd = 1'b1;
      end else if (u > 2 * N) dn = 1'b1;
    end
    return {clr, ~ld, ~wr, ~rd, ir, ld | wr, ~dn, dn};
  endfunction

  task automatic run_row(input int r);
    row_t       v;
    int         t, k, rdy, addr_t, write_t, last_write, gap_until;
    int         done_t_v, done_t_n, mism_v, mism_n, bad_t_v, bad_t_n, cont0, bad_ram_v, bad_ram_n;
    int         sum_img, sum_ram;
    bit         valid, waiting, aborted;
    logic [7:0] ev, en, av, an, bad_a_v, bad_e_v, bad_a_n, bad_e_n, want_v;
    string      tag;
    v   = tbl[r];
    tag = $sformatf("row%0d", r);
    for (int i = 0; i < N; i++)
      img[i] = (v.kind == 0) ? 8'(i) : (v.kind == 1) ? 8'($urandom) : 8'hFF;
    corrupt_idx = v.corrupt;
    fill_req = 1'b1;
    @(posedge clk); @(negedge clk);
    fill_req = 1'b0;
    cont0 = contention;
    start = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    t = 0; k = 0; rdy = 1; addr_t = -10; write_t = -10; last_write = 1 << 30; gap_until = -1;
    done_t_v = -1; done_t_n = -1; mism_v = 0; mism_n = 0; aborted = 1'b0;
    bad_t_v = 0; bad_t_n = 0; bad_a_v = 0; bad_e_v = 0; bad_a_n = 0; bad_e_n = 0;
    while (t < 1000) begin
      ev = exp_vec(1'b1, t, k, rdy, addr_t, write_t, last_write);
      en = exp_vec(1'b0, t, k, rdy, addr_t, write_t, last_write);
      av = {clear_addr_reg_v, load_addr_reg_v, write_enable_v, output_enable_v, in_ready_v, bus_drive_v, busy_v, done_v};
      an = {clear_addr_reg_n, load_addr_reg_n, write_enable_n, output_enable_n, in_ready_n, bus_drive_n, busy_n, done_n};
      if (av !== ev) begin
        if (mism_v == 0) begin bad_t_v = t; bad_a_v = av; bad_e_v = ev; end
        mism_v++;
      end
      if (an !== en) begin
        if (mism_n == 0) begin bad_t_n = t; bad_a_n = an; bad_e_n = en; end
        mism_n++;
      end
      if (done_v === 1'b1 && done_t_v < 0) done_t_v = t;
      if (done_n === 1'b1 && done_t_n < 0) done_t_n = t;
      if (v.abort_byte >= 0 && k == v.abort_byte + 1 && t == write_t) begin
        aborted = 1'b1;
        break;
      end
      if (k == N && t > last_write + 2 * N + 2) break;
      waiting  = (k < N) && (t >= rdy);
      valid    = (t <= gap_until) ? 1'b0 : (v.rate >= 100) ? 1'b1 : ($urandom_range(99) < v.rate);
      start    = (t == v.mid_start);
      in_valid = valid;
      in_data  = waiting ? img[k] : 8'($urandom);
      if (waiting && valid) begin
        addr_t  = t + 1;
        write_t = t + 2;
        rdy     = t + 3;
        if (k == v.gap_after) gap_until = t + v.gap_len;
        k++;
        if (k == N) last_write = t + 2;
      end
      @(posedge clk); @(negedge clk);
      t++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check($sformatf("%s timeline verify, first bad cycle %0d vec %b want %b (bad cycles)", tag, bad_t_v, bad_a_v, bad_e_v), mism_v, 0);
    check($sformatf("%s timeline no-verify, first bad cycle %0d vec %b want %b (bad cycles)", tag, bad_t_n, bad_a_n, bad_e_n), mism_n, 0);
    if (aborted) begin
      clear = 1'b1;
      @(posedge clk); @(negedge clk);
      clear = 1'b0;
      check_reset({tag, " abort"});
      return;
    end
    check({tag, " run completes"}, t < 1000, 1);
    sum_img = 0; sum_ram = 0; bad_ram_v = 0; bad_ram_n = 0;
    for (int i = 0; i < N; i++) begin
      want_v  = (i == v.corrupt) ? ((img[i] == 8'hFF) ? 8'h00 : 8'hFF) : img[i];
      sum_img = sum_img + int'(img[i]);
      sum_ram = sum_ram + int'(want_v);
      if (ram_v[i] !== want_v) bad_ram_v++;
      if (ram_n[i] !== img[i]) bad_ram_n++;
    end
    check({tag, " ram image verify (bad bytes)"}, bad_ram_v, 0);
    check({tag, " ram image no-verify (bad bytes)"}, bad_ram_n, 0);
    check({tag, " checksum verify"}, checksum_v, sum_img % 256);
    check({tag, " checksum no-verify"}, checksum_n, sum_img % 256);
    if (v.has_ck) check({tag, " checksum constant"}, checksum_v, v.exp_ck);
    check({tag, " error verify"}, error_v, (sum_ram % 256) != (sum_img % 256));
    check({tag, " error no-verify"}, error_n, 0);
    if (v.exp_done_n > 0) check({tag, " done latency no-verify"}, done_t_n, v.exp_done_n);
    if (v.exp_done_v > 0) check({tag, " done latency verify"}, done_t_v, v.exp_done_v);
    check({tag, " bus contention cycles"}, contention - cont0, 0);
  endtask

  initial begin
    //           kind rate gap_a gap_l mid  abort corr has exp_ck dn  dv
    tbl[0] = '{0, 100, -1, 0, -1, -1, -1, 1'b1, 8'h78, 49, 82};
    tbl[1] = '{0, 100, -1, 0, -1, -1,  5, 1'b1, 8'h78, 49, 82};
    tbl[2] = '{0, 100,  3, 7, 20, -1, -1, 1'b1, 8'h78, 54, 87};
    tbl[3] = '{1, 100, -1, 0, -1,  9, -1, 1'b0, 8'h00,  0,  0};
    tbl[4] = '{1,  50, -1, 0, -1, -1, -1, 1'b0, 8'h00,  0,  0};
    tbl[5] = '{2, 100, -1, 0, -1, -1, -1, 1'b1, 8'hF0, 49, 82};
    tbl[6] = '{1,  75, -1, 0, -1, -1, 15, 1'b0, 8'h00,  0,  0};
    tbl[7] = '{1, 100, -1, 0, -1, -1,  0, 1'b0, 8'h00, 49, 82};
    clear    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    fill_req = 1'b0;
    for (int i = 0; i < N; i++) img[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("power-on");
    clear = 1'b0;
    for (int r = 0; r < 8; r++) run_row(r);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
